// File: rtl/lsab_write_arbiter_if.sv
// lsab_write_arbiter_if: request/write bundle between the four LSAB write requesters and the arbiter
interface lsab_write_arbiter_if;
    logic [3:0] REQ;
    logic [3:0] WRITE;
    logic       STALL;
    logic [3:0] ERR_CLR;
    logic [1:0] TURN;
    logic [3:0] GRANT;
    logic       GRANT_VLD;
    logic       GRANT_LAST;
    logic       WRITE_OUT;
    logic [3:0] DROP_ERR;

    modport master (
        output REQ, WRITE, STALL, ERR_CLR,
        input  TURN, GRANT, GRANT_VLD, GRANT_LAST, WRITE_OUT, DROP_ERR
    );

    modport slave (
        input  REQ, WRITE, STALL, ERR_CLR,
        output TURN, GRANT, GRANT_VLD, GRANT_LAST, WRITE_OUT, DROP_ERR
    );
endinterface

// File: rtl/lsab_write_arbiter.sv
// lsab_write_arbiter: round-robin owner of the LSAB card-to-RAM write channel
// with bounded bursts, one dead cycle per handover and sticky illegal-write flags.
module lsab_write_arbiter #(
    parameter int BURST_MAX = 16
) (
    input logic CLK,
    input logic RST,
    lsab_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWITCH, GRANT} arbState;

    localparam logic [7:0] burstMax = 8'(BURST_MAX);

    arbState    state, stateNext;
    logic [1:0] turn, turnNext, last, lastNext, otherPick;
    logic [7:0] cnt, cntNext;
    logic [3:0] grantVec, otherReq;
    logic       grantLast, accept, anyOther;
    logic [3:0] dropErr;

    // First requester strictly after 'from', wrapping; 'from' itself is checked last.
    function automatic logic [1:0] pickNext(input logic [3:0] req, input logic [1:0] from);
        logic [1:0] idx;
        pickNext = from;
        for (int i = 4; i >= 1; i--) begin
            idx = from + 2'(i);
            if (req[idx]) pickNext = idx;
        end
    endfunction

    assign grantVec  = (state == GRANT) ? 4'b0001 << turn : 4'b0000;
    assign accept    = (state == GRANT) && bus.WRITE[turn] && !bus.STALL;
    assign otherReq  = bus.REQ & ~(4'b0001 << turn);
    assign anyOther  = |otherReq;
    assign otherPick = pickNext(otherReq, turn);

    always_comb begin
        stateNext = state;
        turnNext  = turn;
        lastNext  = last;
        cntNext   = cnt;
        case (state)
            IDLE: if (|bus.REQ) begin
                stateNext = SWITCH;
                turnNext  = pickNext(bus.REQ, last);
                cntNext   = '0;
            end
            SWITCH: begin
                stateNext = GRANT;
                lastNext  = turn;
            end
            default: if (!bus.REQ[turn]) begin
                stateNext = anyOther ? SWITCH : IDLE;
                turnNext  = anyOther ? otherPick : turn;
                cntNext   = '0;
            end else if (accept) begin
                cntNext   = (cnt == burstMax - 8'd1) ? 8'd0 : cnt + 8'd1;
                // A full burst hands over only if someone else is waiting.
                stateNext = (cnt == burstMax - 8'd1 && anyOther) ? SWITCH : GRANT;
                turnNext  = (cnt == burstMax - 8'd1 && anyOther) ? otherPick : turn;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            turn      <= 2'd0;
            last      <= 2'd3;
            cnt       <= 8'd0;
            grantLast <= 1'b0;
            dropErr   <= 4'b0000;
        end else begin
            state     <= stateNext;
            turn      <= turnNext;
            last      <= lastNext;
            cnt       <= cntNext;
            grantLast <= (stateNext == GRANT) && (cntNext == burstMax - 8'd1);
            dropErr   <= (dropErr & ~bus.ERR_CLR) | (bus.WRITE & ~grantVec);
        end
    end

    assign bus.TURN       = turn;
    assign bus.GRANT      = grantVec;
    assign bus.GRANT_VLD  = (state == GRANT);
    assign bus.GRANT_LAST = grantLast;
    assign bus.WRITE_OUT  = accept;
    assign bus.DROP_ERR   = dropErr;
endmodule

// File: tb/tb_lsab_write_arbiter.sv
// tb_lsab_write_arbiter: directed scenarios for the LSAB write arbiter
// with BURST_MAX=4 (main instance) and BURST_MAX=16 (rollover instance).
module tb_lsab_write_arbiter;
    logic       clk, rst, stall;
    logic [3:0] req, wr, errClr;
    int         total = 0;
    int         bad = 0;

    lsab_write_arbiter_if b4 ();
    lsab_write_arbiter_if b16 ();

    assign b4.REQ      = req;
    assign b4.WRITE    = wr;
    assign b4.STALL    = stall;
    assign b4.ERR_CLR  = errClr;
    assign b16.REQ     = req;
    assign b16.WRITE   = wr;
    assign b16.STALL   = stall;
    assign b16.ERR_CLR = errClr;

    lsab_write_arbiter #(.BURST_MAX(4)) dut (.CLK(clk), .RST(rst), .bus(b4));
    lsab_write_arbiter #(.BURST_MAX(16)) dut16 (.CLK(clk), .RST(rst), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b0; req = '0; wr = '0; stall = 1'b0; errClr = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        doReset();
        total++; if (b4.TURN !== 2'd0) begin bad++; $display("FAIL reset_turn got=%0d exp=0", b4.TURN); end
        total++; if (b4.GRANT !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", b4.GRANT); end
        total++; if (b4.GRANT_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", b4.GRANT_VLD); end
        total++; if (b4.GRANT_LAST !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", b4.GRANT_LAST); end
        total++; if (b4.WRITE_OUT !== 1'b0) begin bad++; $display("FAIL reset_wout got=%b exp=0", b4.WRITE_OUT); end
        total++; if (b4.DROP_ERR !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=0000", b4.DROP_ERR); end
    endtask

    task automatic test_rollover;
        doReset();
        req = 4'b0001;
        #1;
        tick();
        total++; if (b16.TURN !== 2'd0 || b16.GRANT_VLD !== 1'b0) begin bad++; $display("FAIL roll_switch got turn=%0d vld=%b exp turn=0 vld=0", b16.TURN, b16.GRANT_VLD); end
        tick();
        total++; if (b16.GRANT_VLD !== 1'b1 || b16.GRANT !== 4'b0001) begin bad++; $display("FAIL roll_grant got vld=%b grant=%b exp vld=1 grant=0001", b16.GRANT_VLD, b16.GRANT); end
        wr = 4'b0001;
        #1;
        for (int i = 0; i < 40; i++) begin
            total++; if (b16.WRITE_OUT !== 1'b1 || b16.GRANT_VLD !== 1'b1) begin bad++; $display("FAIL roll_word%0d got wout=%b vld=%b exp 1 1", i, b16.WRITE_OUT, b16.GRANT_VLD); end
            total++; if (b16.GRANT_LAST !== (i % 16 == 15)) begin bad++; $display("FAIL roll_last%0d got=%b exp=%b", i, b16.GRANT_LAST, i % 16 == 15); end
            tick();
        end
        total++; if (b16.DROP_ERR !== 4'b0000) begin bad++; $display("FAIL roll_err got=%b exp=0000", b16.DROP_ERR); end
        req = '0; wr = '0;
        tick();
    endtask

    task automatic test_round_robin;
        logic [1:0] expTurn;
        logic [1:0] nextTurn;
        doReset();
        req = 4'b1111; wr = 4'b1111;
        #1;
        tick();
        total++; if (b4.TURN !== 2'd0 || b4.GRANT_VLD !== 1'b0) begin bad++; $display("FAIL rr_first got turn=%0d vld=%b exp turn=0 vld=0", b4.TURN, b4.GRANT_VLD); end
        tick();
        for (int b = 0; b < 5; b++) begin
            expTurn = 2'(b);
            nextTurn = 2'(b + 1);
            for (int w = 0; w < 4; w++) begin
                total++; if (b4.TURN !== expTurn || b4.GRANT !== (4'b0001 << expTurn) || b4.GRANT_VLD !== 1'b1) begin bad++; $display("FAIL rr_grant b%0d w%0d got turn=%0d grant=%b vld=%b exp turn=%0d", b, w, b4.TURN, b4.GRANT, b4.GRANT_VLD, expTurn); end
                total++; if (b4.WRITE_OUT !== 1'b1) begin bad++; $display("FAIL rr_wout b%0d w%0d got=%b exp=1", b, w, b4.WRITE_OUT); end
                total++; if (b4.GRANT_LAST !== (w == 3)) begin bad++; $display("FAIL rr_last b%0d w%0d got=%b exp=%b", b, w, b4.GRANT_LAST, w == 3); end
                tick();
            end
            total++; if (b4.GRANT_VLD !== 1'b0 || b4.WRITE_OUT !== 1'b0 || b4.GRANT !== 4'b0000 || b4.TURN !== nextTurn) begin bad++; $display("FAIL rr_dead b%0d got vld=%b wout=%b grant=%b turn=%0d exp 0 0 0000 %0d", b, b4.GRANT_VLD, b4.WRITE_OUT, b4.GRANT, b4.TURN, nextTurn); end
            tick();
        end
        total++; if (b4.DROP_ERR !== 4'b1111) begin bad++; $display("FAIL rr_err got=%b exp=1111", b4.DROP_ERR); end
        req = '0; wr = '0;
        tick();
    endtask

    task automatic test_stall;
        doReset();
        req = 4'b0100;
        #1;
        tick();
        tick();
        wr = 4'b0100;
        #1;
        for (int w = 0; w < 2; w++) begin
            total++; if (b4.WRITE_OUT !== 1'b1 || b4.TURN !== 2'd2) begin bad++; $display("FAIL stall_pre%0d got wout=%b turn=%0d exp 1 2", w, b4.WRITE_OUT, b4.TURN); end
            tick();
        end
        stall = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            total++; if (b4.WRITE_OUT !== 1'b0 || b4.GRANT !== 4'b0100 || b4.GRANT_VLD !== 1'b1 || b4.GRANT_LAST !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got wout=%b grant=%b vld=%b last=%b exp 0 0100 1 0", s, b4.WRITE_OUT, b4.GRANT, b4.GRANT_VLD, b4.GRANT_LAST); end
            tick();
        end
        stall = 1'b0;
        #1;
        total++; if (b4.WRITE_OUT !== 1'b1 || b4.GRANT_LAST !== 1'b0) begin bad++; $display("FAIL stall_w3 got wout=%b last=%b exp 1 0", b4.WRITE_OUT, b4.GRANT_LAST); end
        tick();
        total++; if (b4.WRITE_OUT !== 1'b1 || b4.GRANT_LAST !== 1'b1) begin bad++; $display("FAIL stall_w4 got wout=%b last=%b exp 1 1", b4.WRITE_OUT, b4.GRANT_LAST); end
        tick();
        total++; if (b4.GRANT_VLD !== 1'b1 || b4.GRANT_LAST !== 1'b0 || b4.TURN !== 2'd2) begin bad++; $display("FAIL stall_wrap got vld=%b last=%b turn=%0d exp 1 0 2", b4.GRANT_VLD, b4.GRANT_LAST, b4.TURN); end
        total++; if (b4.DROP_ERR !== 4'b0000) begin bad++; $display("FAIL stall_err got=%b exp=0000", b4.DROP_ERR); end
        req = '0; wr = '0;
        tick();
    endtask

    task automatic test_drop_err;
        doReset();
        req = 4'b0010;
        #1;
        tick();
        tick();
        wr = 4'b1010;
        #1;
        total++; if (b4.WRITE_OUT !== 1'b1) begin bad++; $display("FAIL err_wout_granted got=%b exp=1", b4.WRITE_OUT); end
        tick();
        wr = 4'b0000;
        #1;
        total++; if (b4.DROP_ERR !== 4'b1000) begin bad++; $display("FAIL err_set got=%b exp=1000", b4.DROP_ERR); end
        wr = 4'b1000; errClr = 4'b1000;
        #1;
        total++; if (b4.WRITE_OUT !== 1'b0) begin bad++; $display("FAIL err_no_leak got=%b exp=0", b4.WRITE_OUT); end
        tick();
        total++; if (b4.DROP_ERR !== 4'b1000) begin bad++; $display("FAIL err_set_wins got=%b exp=1000", b4.DROP_ERR); end
        wr = 4'b0000;
        #1;
        tick();
        total++; if (b4.DROP_ERR !== 4'b0000) begin bad++; $display("FAIL err_clear got=%b exp=0000", b4.DROP_ERR); end
        errClr = '0; req = '0;
        tick();
    endtask

    task automatic test_release;
        doReset();
        req = 4'b0101;
        #1;
        tick();
        total++; if (b4.TURN !== 2'd0) begin bad++; $display("FAIL rel_pick got=%0d exp=0", b4.TURN); end
        tick();
        wr = 4'b0001;
        #1;
        for (int w = 0; w < 3; w++) begin
            total++; if (b4.WRITE_OUT !== 1'b1 || b4.GRANT !== 4'b0001) begin bad++; $display("FAIL rel_word%0d got wout=%b grant=%b exp 1 0001", w, b4.WRITE_OUT, b4.GRANT); end
            tick();
        end
        req = 4'b0100;
        #1;
        total++; if (b4.WRITE_OUT !== 1'b1 || b4.GRANT_VLD !== 1'b1) begin bad++; $display("FAIL rel_last_word got wout=%b vld=%b exp 1 1", b4.WRITE_OUT, b4.GRANT_VLD); end
        tick();
        wr = '0;
        #1;
        total++; if (b4.GRANT_VLD !== 1'b0 || b4.TURN !== 2'd2) begin bad++; $display("FAIL rel_switch got vld=%b turn=%0d exp 0 2", b4.GRANT_VLD, b4.TURN); end
        tick();
        total++; if (b4.GRANT_VLD !== 1'b1 || b4.GRANT !== 4'b0100) begin bad++; $display("FAIL rel_new got vld=%b grant=%b exp 1 0100", b4.GRANT_VLD, b4.GRANT); end
        req = '0;
        #1;
        tick();
        total++; if (b4.GRANT_VLD !== 1'b0 || b4.GRANT !== 4'b0000) begin bad++; $display("FAIL rel_idle got vld=%b grant=%b exp 0 0000", b4.GRANT_VLD, b4.GRANT); end
        tick();
        total++; if (b4.GRANT_VLD !== 1'b0 || b4.TURN !== 2'd2) begin bad++; $display("FAIL rel_stay_idle got vld=%b turn=%0d exp 0 2", b4.GRANT_VLD, b4.TURN); end
    endtask

    task automatic test_reset_mid_burst;
        doReset();
        req = 4'b1000;
        #1;
        tick();
        total++; if (b4.TURN !== 2'd3) begin bad++; $display("FAIL rst_pick got=%0d exp=3", b4.TURN); end
        tick();
        wr = 4'b1000;
        #1;
        total++; if (b4.WRITE_OUT !== 1'b1) begin bad++; $display("FAIL rst_burst got=%b exp=1", b4.WRITE_OUT); end
        tick();
        rst = 1'b0;
        #1;
        tick();
        total++; if (b4.TURN !== 2'd0 || b4.GRANT !== 4'b0000 || b4.GRANT_VLD !== 1'b0 || b4.GRANT_LAST !== 1'b0 || b4.WRITE_OUT !== 1'b0 || b4.DROP_ERR !== 4'b0000) begin bad++; $display("FAIL rst_abort got turn=%0d grant=%b vld=%b last=%b wout=%b err=%b exp all 0", b4.TURN, b4.GRANT, b4.GRANT_VLD, b4.GRANT_LAST, b4.WRITE_OUT, b4.DROP_ERR); end
        rst = 1'b1; req = 4'b1001; wr = '0;
        #1;
        tick();
        total++; if (b4.TURN !== 2'd0 || b4.GRANT_VLD !== 1'b0) begin bad++; $display("FAIL rst_regrant_switch got turn=%0d vld=%b exp 0 0", b4.TURN, b4.GRANT_VLD); end
        tick();
        total++; if (b4.GRANT !== 4'b0001) begin bad++; $display("FAIL rst_regrant got=%b exp=0001", b4.GRANT); end
        req = 4'b1000;
        #1;
        tick();
        total++; if (b4.TURN !== 2'd3 || b4.GRANT_VLD !== 1'b0) begin bad++; $display("FAIL rst_next got turn=%0d vld=%b exp 3 0", b4.TURN, b4.GRANT_VLD); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_round_robin();
        test_stall();
        test_drop_err();
        test_release();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsab_write_arbiter.md
# lsab_write_arbiter

Round-robin scheduler that shares the single LSAB card-to-RAM write channel (the `write_fifo_cr` turn selector of the core) among four peripheral requesters; the Ethernet MAC is requester 0. It drives the 2-bit turn selector, issues one-hot grants with a bounded burst length, forwards only the granted channel's write strobe, and flags writes from channels that do not hold the turn.

## Interface
- `BURST_MAX`, 16: maximum accepted words per grant; legal range 1..255.
- `CLK` in 1: system clock (the core's `CLK_n` domain).
- `RST` in 1: reset; synchronous, active-low.
- `REQ` in 4: per-requester level request; high while the requester has words to write.
- `WRITE` in 4: per-requester write strobe, one word per cycle.
- `STALL` in 1: LSAB backpressure; while high no word is accepted.
- `ERR_CLR` in 4: per-channel clear for `DROP_ERR`.
- `TURN` out 2: granted channel index, wired to `write_fifo_cr`.
- `GRANT` out 4: one-hot grant; all zero when `GRANT_VLD` is low.
- `GRANT_VLD` out 1: a grant is active.
- `GRANT_LAST` out 1: the next accepted word ends the burst.
- `WRITE_OUT` out 1: gated write strobe to the core.
- `DROP_ERR` out 4: sticky per-channel illegal-write flag.

## Operation
- State machine with three states:
  - IDLE: if any `REQ` is high, select the first requesting channel searching upward from `last+1` mod 4, with wrap. Load `TURN`, clear `cnt`, go to SWITCH.
  - SWITCH: one dead cycle; `GRANT_VLD`=0. On exit, set `last`<=`TURN` and go to GRANT.
  - GRANT: `GRANT_VLD`=1 and `GRANT[TURN]`=1. A word is accepted when `WRITE[TURN]` & !`STALL`; each accepted word increments `cnt`.
- Exit conditions, evaluated each GRANT cycle in priority order:
  1. `REQ[TURN]` low: if another channel requests, pick by round-robin and go to SWITCH; otherwise go to IDLE.
  2. Accepted word brings `cnt` to `BURST_MAX`: if another channel requests, rotate to it via SWITCH. If none does and `REQ[TURN]` is still high, clear `cnt` and stay in GRANT with no dead cycle.
- `WRITE_OUT` is combinational: `GRANT_VLD` & `WRITE[TURN]` & !`STALL`.
- `GRANT_LAST` is registered: high in GRANT when `cnt` == `BURST_MAX`-1.
- `cnt` is 8 bits wide; it never exceeds `BURST_MAX`.
- `DROP_ERR[i]` is set when `WRITE[i]` is high and either `GRANT[i]` is low, or the state is IDLE or SWITCH. A write during `STALL` on the granted channel is not an error; the word is simply not accepted.
- If set and clear of `DROP_ERR[i]` coincide, set wins.
- A write dropped from a non-granted channel never reaches `WRITE_OUT`.

## Timing
- Reset values: `TURN`=0, `GRANT`=0, `GRANT_VLD`=0, `GRANT_LAST`=0, `WRITE_OUT`=0 (follows from `GRANT_VLD`=0), `DROP_ERR`=0, `cnt`=0, state IDLE, `last`=3. The first grant after reset therefore goes to channel 0 when it requests.
- Reset asserted mid-burst aborts at the next edge; no further strobe reaches `WRITE_OUT`.
- Request to grant: `REQ` sampled high in IDLE at edge k. `TURN` is valid after edge k; `GRANT_VLD` rises after edge k+1.
- Handover: the release or rotate decision at edge k gives a SWITCH cycle, then the new `GRANT` after edge k+1. There is exactly one dead cycle. `TURN` changes only on entry to SWITCH.
- The cycle that carries the `BURST_MAX`-th accepted word still has `GRANT_VLD` high. After a rotate, `GRANT_VLD` is low in the following cycle, so a write there sets `DROP_ERR`.
- `STALL` freezes `cnt`; the grant is held.
- A `REQ` drop is seen at the edge; a `WRITE` in the same cycle as `REQ` low is still accepted.
- The grant never changes while `STALL` is high unless `REQ[TURN]` drops.

## Test plan
- After reset, `REQ`=4'b0001 and channel 0 writes continuously -> `TURN`=0, `GRANT_VLD` high 2 cycles after `REQ`, `WRITE_OUT` pulses every cycle, `cnt` rolls over at 16 with no dead cycle, `DROP_ERR`=0.
- `REQ`=4'b1111, all channels write continuously, `BURST_MAX`=4 -> grant order 0,1,2,3,0. Each burst is 4 `WRITE_OUT` pulses followed by 1 dead cycle. `GRANT_LAST` is high on the 4th word of every burst.
- Channel 2 granted, `STALL` high for 5 cycles mid-burst -> `cnt` holds, `WRITE_OUT`=0, grant kept, `DROP_ERR`=0. After `STALL` drops, the burst completes with the full count.
- Channel 1 granted, channel 3 asserts `WRITE` for one cycle -> `DROP_ERR`=4'b1000 and `WRITE_OUT` is unaffected. `ERR_CLR[3]` pulsed in the same cycle as a new illegal write -> bit stays 1. A clear alone -> bit 0.
- Channel 0 drops `REQ` after 3 words while channel 2 is requesting -> SWITCH, then `TURN`=2 with one dead cycle. With no other requester -> IDLE and `GRANT`=0.
- `RST` asserted during a burst on channel 3 -> all outputs 0 after the edge. The next request from channels 0 and 3 together is granted to channel 0 first.
